// File: rtl/boolean_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// boolean_sweep_ctrl_if
//   Bundle between a test/config master and the boolean sweep sequencer.
//   The sequencer (slave side) also drives the boolean function block inputs
//   (abcd) and reads its output (Y), so both live on this bundle.
//
// Signals:
//   start         master -> slave  begin a sweep (honoured only when idle)
//   abort         master -> slave  terminate a running sweep
//   expected      master -> slave  expected truth table, bit i = Y for vector i
//   Y             block  -> slave  boolean function output
//   abcd          slave  -> block  vector driven to the function block
//   busy          slave  -> master sweep in progress (SETTLE/SAMPLE/DONE)
//   done          slave  -> master one-cycle end-of-sweep pulse
//   tt            slave  -> master captured truth table
//   pass          slave  -> master tt matched expected on a complete sweep
//   mismatch_cnt  slave  -> master number of mismatching vectors
//   fail_idx      slave  -> master index of the first mismatching vector
// ---------------------------------------------------------------------------
interface boolean_sweep_ctrl_if #(
    parameter int N_IN = 4
);
    logic                start;
    logic                abort;
    logic [2**N_IN-1:0]  expected;
    logic                Y;
    logic [N_IN-1:0]     abcd;
    logic                busy;
    logic                done;
    logic [2**N_IN-1:0]  tt;
    logic                pass;
    logic [N_IN:0]       mismatch_cnt;
    logic [N_IN-1:0]     fail_idx;

    modport master (
        output start, abort, expected, Y,
        input  abcd, busy, done, tt, pass, mismatch_cnt, fail_idx
    );

    modport slave (
        input  start, abort, expected, Y,
        output abcd, busy, done, tt, pass, mismatch_cnt, fail_idx
    );
endinterface

// File: rtl/boolean_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// boolean_sweep_ctrl
//   Exhaustively sweeps a 2**N_IN-entry boolean function block. Each vector
//   is held SETTLE cycles, then Y is sampled into a truth table and compared
//   against the expected table latched when the sweep was started.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   boolean_sweep_ctrl_if.slave (start/abort/expected/Y in,
//         abcd/busy/done/tt/pass/mismatch_cnt/fail_idx out)
//
// Parameters:
//   N_IN    number of function inputs (sweep covers 2**N_IN vectors)
//   SETTLE  cycles each vector is held before sampling, 1..255
//
// Optional feature (macro BOOLEAN_SWEEP_STOP_ON_FAIL_EN):
//   When defined, the first mismatch ends the sweep immediately.
// ---------------------------------------------------------------------------
module boolean_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    boolean_sweep_ctrl_if.slave  bus
);
    localparam int N_VEC = 2**N_IN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_IN-1:0]     abcd_q, abcd_d;
    logic [N_VEC-1:0]    exp_q, exp_d;
    logic [N_VEC-1:0]    tt_q, tt_d;
    logic                pass_q, pass_d;
    logic [N_IN:0]       mismatch_cnt_q, mismatch_cnt_d;
    logic [N_IN-1:0]     fail_idx_q, fail_idx_d;
    logic                fail_seen_q, fail_seen_d;

    logic settle_end;
    logic last_vec;
    logic miss;

    assign settle_end = (cnt_q == 8'(SETTLE - 1));
    assign last_vec   = (abcd_q == {N_IN{1'b1}});
    assign miss       = (bus.Y != exp_q[abcd_q]);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            abcd_q         <= '0;
            exp_q          <= '0;
            tt_q           <= '0;
            pass_q         <= 1'b0;
            mismatch_cnt_q <= '0;
            fail_idx_q     <= '0;
            fail_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            abcd_q         <= abcd_d;
            exp_q          <= exp_d;
            tt_q           <= tt_d;
            pass_q         <= pass_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            fail_idx_q     <= fail_idx_d;
            fail_seen_q    <= fail_seen_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_SETTLE;
            S_SETTLE: begin
                if (bus.abort)       state_d = S_DONE;
                else if (settle_end) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                // Abort still lets this cycle's capture complete (datapath).
                if (bus.abort || last_vec) state_d = S_DONE;
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
                else if (miss)             state_d = S_DONE;
`endif
                else                       state_d = S_SETTLE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d          = cnt_q;
        abcd_d         = abcd_q;
        exp_d          = exp_q;
        tt_d           = tt_q;
        pass_d         = pass_q;
        mismatch_cnt_d = mismatch_cnt_q;
        fail_idx_d     = fail_idx_q;
        fail_seen_d    = fail_seen_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    exp_d          = bus.expected;
                    abcd_d         = '0;
                    tt_d           = '0;
                    mismatch_cnt_d = '0;
                    fail_idx_d     = '0;
                    fail_seen_d    = 1'b0;
                    pass_d         = 1'b0;
                    cnt_d          = '0;
                end
            end
            S_SETTLE: begin
                if (bus.abort || settle_end) cnt_d = '0;
                else                         cnt_d = cnt_q + 8'd1;
            end
            S_SAMPLE: begin
                tt_d[abcd_q] = bus.Y;
                if (miss) begin
                    mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                    if (!fail_seen_q) begin
                        fail_idx_d  = abcd_q;
                        fail_seen_d = 1'b1;
                    end
                end
                if (state_d == S_SETTLE) abcd_d = abcd_q + 1'b1;
                // pass is registered on DONE entry so it is valid while done=1.
                if (state_d == S_DONE)
                    pass_d = (mismatch_cnt_d == '0) && !bus.abort;
            end
            S_DONE: abcd_d = '0;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
    end

    assign bus.abcd         = abcd_q;
    assign bus.tt           = tt_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
    assign bus.fail_idx     = fail_idx_q;
endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
module tb_boolean_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   model_zero = 1'b0;   // 0: Y=(A&B)|(C&D), 1: Y=0

    boolean_sweep_ctrl_if #(.N_IN(4)) bus ();

    boolean_sweep_ctrl #(.N_IN(4), .SETTLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.Y = model_zero ? 1'b0
                 : ((bus.abcd[3] & bus.abcd[2]) | (bus.abcd[1] & bus.abcd[0]));

    // Start a sweep and watch it. n counts edges after the start edge k;
    // done appearing after edge k+n means done is high in cycle k+n+1.
    // Returns -1 in n_done if done never appears within the budget.
    task automatic sweep(input logic [15:0] exp_tt, input int abort_at,
                         input bit repulse, output int n_done,
                         output int abcd_err);
        int exp_v;
        @(negedge clk);
        bus.expected = exp_tt;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (repulse) bus.expected = 16'h0000;
        n_done   = -1;
        abcd_err = 0;
        for (int n = 1; n <= 60; n++) begin
            if (repulse && (n == 5 || n == 48)) bus.start = 1'b1;
            if (n == abort_at) bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.done) begin
                n_done = n;
                break;
            end
            exp_v = (n / 3 > 15) ? 15 : n / 3;
            if (bus.abcd !== 4'(exp_v)) abcd_err++;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.expected = 16'hFFFF;
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({bus.abcd, bus.busy, bus.done, bus.tt, bus.pass, bus.mismatch_cnt, bus.fail_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got abcd=%h busy=%b done=%b tt=%h pass=%b mc=%0d fi=%0d, required all zero",
                     bus.abcd, bus.busy, bus.done, bus.tt, bus.pass, bus.mismatch_cnt, bus.fail_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_busy: got %b required 0", bus.busy);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_sweep;
        int nd, ae;
        model_zero = 1'b0;
        sweep(16'hF888, 0, 1'b0, nd, ae);
        n_assert++;
        if (nd !== 48) begin n_fail++; $display("FAIL full_done_cycle: got %0d required 48", nd); end
        n_assert++;
        if (ae !== 0) begin n_fail++; $display("FAIL full_abcd_steps: got %0d bad cycles required 0", ae); end
        n_assert++;
        if (bus.tt !== 16'hF888) begin n_fail++; $display("FAIL full_tt: got %h required f888", bus.tt); end
        n_assert++;
        if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL full_pass: got %b required 1", bus.pass); end
        n_assert++;
        if (bus.mismatch_cnt !== 5'd0 || bus.fail_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL full_counts: got mc=%0d fi=%0d required 0 0", bus.mismatch_cnt, bus.fail_idx);
        end
        n_assert++;
        if (bus.busy !== 1'b1 || bus.abcd !== 4'd15) begin
            n_fail++;
            $display("FAIL full_done_cycle_state: got busy=%b abcd=%0d required 1 15", bus.busy, bus.abcd);
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.abcd !== 4'd0 || bus.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_done: got done=%b busy=%b abcd=%0d pass=%b required 0 0 0 1",
                     bus.done, bus.busy, bus.abcd, bus.pass);
        end
    endtask

    task automatic test_single_mismatch;
        int nd, ae;
        model_zero = 1'b0;
        sweep(16'hF88C, 0, 1'b0, nd, ae);
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
        n_assert++;
        if (nd !== 9) begin n_fail++; $display("FAIL mis1_done_cycle: got %0d required 9", nd); end
        n_assert++;
        if (bus.tt !== 16'h0000) begin n_fail++; $display("FAIL mis1_tt: got %h required 0000", bus.tt); end
`else
        n_assert++;
        if (nd !== 48) begin n_fail++; $display("FAIL mis1_done_cycle: got %0d required 48", nd); end
        n_assert++;
        if (bus.tt !== 16'hF888) begin n_fail++; $display("FAIL mis1_tt: got %h required f888", bus.tt); end
`endif
        n_assert++;
        if (bus.pass !== 1'b0 || bus.mismatch_cnt !== 5'd1 || bus.fail_idx !== 4'd2) begin
            n_fail++;
            $display("FAIL mis1_result: got pass=%b mc=%0d fi=%0d required 0 1 2",
                     bus.pass, bus.mismatch_cnt, bus.fail_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_all_mismatch;
        int nd, ae;
        model_zero = 1'b1;
        sweep(16'hFFFF, 0, 1'b0, nd, ae);
`ifdef BOOLEAN_SWEEP_STOP_ON_FAIL_EN
        n_assert++;
        if (nd !== 3 || bus.mismatch_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL allmis_done: got n=%0d mc=%0d required 3 1", nd, bus.mismatch_cnt);
        end
`else
        n_assert++;
        if (nd !== 48 || bus.mismatch_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL allmis_done: got n=%0d mc=%0d required 48 16", nd, bus.mismatch_cnt);
        end
`endif
        n_assert++;
        if (bus.fail_idx !== 4'd0 || bus.pass !== 1'b0 || bus.tt !== 16'h0000) begin
            n_fail++;
            $display("FAIL allmis_result: got fi=%0d pass=%b tt=%h required 0 0 0000",
                     bus.fail_idx, bus.pass, bus.tt);
        end
        model_zero = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int nd, ae;
        model_zero = 1'b0;
        sweep(16'hF888, 0, 1'b1, nd, ae);
        n_assert++;
        if (nd !== 48 || ae !== 0) begin
            n_fail++;
            $display("FAIL repulse_sweep: got n=%0d abcd_err=%0d required 48 0", nd, ae);
        end
        n_assert++;
        if (bus.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL repulse_exp_kept: got pass=%b required 1", bus.pass);
        end
        // start in the DONE cycle must not begin another sweep
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL repulse_done_start: got busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int nd, ae;
        model_zero = 1'b0;
        sweep(16'hF888, 20, 1'b0, nd, ae);
        n_assert++;
        if (nd !== 20 || ae !== 0) begin
            n_fail++;
            $display("FAIL abort_done_cycle: got n=%0d abcd_err=%0d required 20 0", nd, ae);
        end
        n_assert++;
        if (bus.pass !== 1'b0 || bus.tt !== 16'h0008 || bus.mismatch_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_partial: got pass=%b tt=%h mc=%0d required 0 0008 0",
                     bus.pass, bus.tt, bus.mismatch_cnt);
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_low: got %b required 0", bus.busy); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_sweep;
        int nd, ae;
        int saw_done;
        model_zero = 1'b0;
        saw_done = 0;
        @(negedge clk);
        bus.expected = 16'hF888;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done++;
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if ({bus.abcd, bus.busy, bus.done, bus.tt, bus.pass, bus.mismatch_cnt, bus.fail_idx} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_values: got abcd=%h busy=%b done=%b tt=%h pass=%b mc=%0d fi=%0d required all zero",
                     bus.abcd, bus.busy, bus.done, bus.tt, bus.pass, bus.mismatch_cnt, bus.fail_idx);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done++;
        end
        n_assert++;
        if (saw_done !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses required 0", saw_done); end
        @(negedge clk);
        rst = 1'b0;
        sweep(16'hF888, 0, 1'b0, nd, ae);
        n_assert++;
        if (nd !== 48 || ae !== 0 || bus.pass !== 1'b1 || bus.tt !== 16'hF888) begin
            n_fail++;
            $display("FAIL rst_resweep: got n=%0d abcd_err=%0d pass=%b tt=%h required 48 0 1 f888",
                     nd, ae, bus.pass, bus.tt);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = '0;
        test_reset();
        test_full_sweep();
        test_single_mismatch();
        test_all_mismatch();
        test_start_ignored();
        test_abort();
        test_rst_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
